// File: rtl/tx_sched_pkg.sv
// Shared definitions for the per-port transmit queue scheduler.
// FSM encoding, default field widths and the largest supported queue count.
package tx_sched_pkg;

  localparam int MAX_NQ     = 8;
  localparam int IDX_W      = 3;
  localparam int DEF_PTR_W  = 16;
  localparam int DEF_LEN_W  = 11;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OFFER,
    ST_CAPT,
    ST_XFER
  } state_e;

endpackage

// File: rtl/mac_tx_queue_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting queue after ptr, wrapping NQ-1 -> 0.
// The pointer register itself lives in the parent.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NQ = 4
) (
  input  logic [NQ-1:0]    req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = NQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NQ]) begin
        idx   = IDX_W'((int'(ptr) + k) % NQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_queue_sched.sv
// Shares one GMII tx MAC between NQ egress queues, grant locked per frame.
// Define TXQ_STRICT_PRIO_EN to give queue 0 strict priority over the round-robin set.
module mac_tx_queue_sched
  import tx_sched_pkg::*;
#(
  parameter int NQ     = 4,
  parameter int PTR_W  = DEF_PTR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NQ-1:0]        q_ptr_empty,
  input  logic [NQ*PTR_W-1:0]  q_ptr_dout,
  output logic [NQ-1:0]        q_ptr_rd,
  input  logic [NQ*DATA_W-1:0] q_data_dout,
  output logic [NQ-1:0]        q_data_rd,
  output logic                 mac_ptr_empty,
  output logic [PTR_W-1:0]     mac_ptr_dout,
  input  logic                 mac_ptr_rd,
  output logic [DATA_W-1:0]    mac_data_dout,
  input  logic                 mac_data_rd,
  input  logic                 pause,
  output logic [2:0]           grant_q,
  output logic                 busy,
  output logic                 err
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q_q, grant_q_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               mac_ptr_empty_q, mac_ptr_empty_d;

  logic [PTR_W-1:0]   ptr_arr  [NQ];
  logic [DATA_W-1:0]  data_arr [NQ];
  logic [NQ-1:0]      req;
  logic [NQ-1:0]      arb_req;
  logic [IDX_W-1:0]   arb_idx, win_idx;
  logic               arb_valid, win_valid;
  logic               ptr_fwd, data_fwd;

  assign req      = ~q_ptr_empty;
  assign ptr_fwd  = (state_q == ST_OFFER) && mac_ptr_rd;
  assign data_fwd = (state_q == ST_XFER) && mac_data_rd;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_queue
    assign ptr_arr[gi]   = q_ptr_dout[gi*PTR_W +: PTR_W];
    assign data_arr[gi]  = q_data_dout[gi*DATA_W +: DATA_W];
    assign q_ptr_rd[gi]  = ptr_fwd  && (grant_q_q == IDX_W'(gi));
    assign q_data_rd[gi] = data_fwd && (grant_q_q == IDX_W'(gi));
  end

`ifdef TXQ_STRICT_PRIO_EN
  // Queue 0 bypasses the arbiter; the rest share the round-robin pointer.
  assign arb_req   = req & {{(NQ-1){1'b1}}, 1'b0};
  assign win_idx   = req[0] ? '0 : arb_idx;
  assign win_valid = req[0] | arb_valid;
`else
  assign arb_req   = req;
  assign win_idx   = arb_idx;
  assign win_valid = arb_valid;
`endif

  rr_arbiter #(.NQ(NQ)) u_arb (
    .req   (arb_req),
    .ptr   (rr_q),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Output muxes follow the registered grant, so the last byte outlives the frame.
  always_comb begin
    mac_ptr_dout  = '0;
    mac_data_dout = '0;
    for (int i = 0; i < NQ; i++) begin
      if (grant_q_q == IDX_W'(i)) begin
        mac_ptr_dout  = ptr_arr[i];
        mac_data_dout = data_arr[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_q_d = grant_q_q;
    rr_d      = rr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = (mac_ptr_rd && state_q != ST_OFFER) || (mac_data_rd && state_q != ST_XFER);
    case (state_q)
      ST_IDLE: begin
        if (!pause && |req) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (pause || !win_valid) begin
          state_d = ST_IDLE;
        end else begin
          grant_q_d = win_idx;
`ifdef TXQ_STRICT_PRIO_EN
          if (win_idx != '0) rr_d = win_idx;
`else
          rr_d = win_idx;
`endif
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (mac_ptr_rd) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        len_d = mac_ptr_dout[LEN_W-1:0];
        cnt_d = '0;
        if (len_d == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (mac_data_rd) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d          = (state_d == ST_OFFER) || (state_d == ST_XFER);
    mac_ptr_empty_d = (state_d != ST_OFFER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      grant_q_q       <= '0;
      rr_q            <= IDX_W'(NQ - 1);
      len_q           <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      mac_ptr_empty_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      grant_q_q       <= grant_q_d;
      rr_q            <= rr_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      mac_ptr_empty_q <= mac_ptr_empty_d;
    end
  end

  assign grant_q       = grant_q_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign mac_ptr_empty = mac_ptr_empty_q;

endmodule

// File: tb/tb_mac_tx_queue_sched.sv
// Directed bench for mac_tx_queue_sched: queue FIFO models plus a simple MAC reader.
// Build with TXQ_STRICT_PRIO_EN defined to also exercise strict priority.
module tb_mac_tx_queue_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  q_ptr_empty;
  logic [63:0] q_ptr_dout;
  logic [3:0]  q_ptr_rd;
  logic [31:0] q_data_dout;
  logic [3:0]  q_data_rd;
  logic        mac_ptr_empty;
  logic [15:0] mac_ptr_dout;
  logic        mac_ptr_rd;
  logic [7:0]  mac_data_dout;
  logic        mac_data_rd;
  logic        pause;
  logic [2:0]  grant_q;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_tx_queue_sched #(.NQ(4), .PTR_W(16), .LEN_W(11), .DATA_W(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .q_ptr_empty   (q_ptr_empty),
    .q_ptr_dout    (q_ptr_dout),
    .q_ptr_rd      (q_ptr_rd),
    .q_data_dout   (q_data_dout),
    .q_data_rd     (q_data_rd),
    .mac_ptr_empty (mac_ptr_empty),
    .mac_ptr_dout  (mac_ptr_dout),
    .mac_ptr_rd    (mac_ptr_rd),
    .mac_data_dout (mac_data_dout),
    .mac_data_rd   (mac_data_rd),
    .pause         (pause),
    .grant_q       (grant_q),
    .busy          (busy),
    .err           (err)
  );

  // Queue FIFO models: standard mode, dout updates the cycle after rd.
  logic [15:0] mem [4][16];
  int          wr_ptr [4];
  int          rd_ptr [4];
  logic [15:0] ptr_m [4];
  int          ptr_rd_cnt [4];
  int          data_rd_cnt [4];
  int          err_cnt = 0;
  int          exp_data [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_model
    assign q_ptr_empty[gi]         = (wr_ptr[gi] == rd_ptr[gi]);
    assign q_ptr_dout[gi*16 +: 16] = ptr_m[gi];
    assign q_data_dout[gi*8 +: 8]  = 8'(gi*64 + data_rd_cnt[gi]);
  end

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (q_ptr_rd[i]) begin
          ptr_m[i]      <= mem[i][rd_ptr[i] % 16];
          rd_ptr[i]     <= rd_ptr[i] + 1;
          ptr_rd_cnt[i] <= ptr_rd_cnt[i] + 1;
        end
        if (q_data_rd[i]) data_rd_cnt[i] <= data_rd_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) if (err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic push(input int q, input logic [15:0] d);
    mem[q][wr_ptr[q] % 16] = d;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    mac_ptr_rd = 1'b0;
    mac_data_rd = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // MAC side: wait for a descriptor, read it, then read its bytes back to back.
  task automatic drive_frame(input int push_q, input logic [15:0] push_d, input bit pause_mid,
                             output int g, output logic [15:0] pd, output bit to);
    int k;
    k = 0; to = 1'b0; g = -1; pd = '0;
    while (mac_ptr_empty !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      to = 1'b1;
      return;
    end
    g = int'(grant_q);
    mac_ptr_rd = 1'b1;
    @(negedge clk);
    mac_ptr_rd = 1'b0;
    pd = mac_ptr_dout;
    @(negedge clk);
    for (int i = 0; i < int'(pd[10:0]); i++) begin
      mac_data_rd = 1'b1;
      if (i == 0) begin
        if (pause_mid) pause = 1'b1;
        if (push_q >= 0) push(push_q, push_d);
      end
      @(negedge clk);
    end
    mac_data_rd = 1'b0;
    $display("frame: grant q%0d desc %h len %0d", g, pd, pd[10:0]);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mac_ptr_rd = 1'b0;
    mac_data_rd = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, err, mac_ptr_empty, grant_q} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: busy/err/empty/grant got %b%b%b %0d want 001 0", busy, err, mac_ptr_empty, grant_q);
    end
    n_checks++;
    if ({q_ptr_rd, q_data_rd} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000000", {q_ptr_rd, q_data_rd});
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, mac_ptr_empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_idle_empty: busy/empty got %b%b want 01", busy, mac_ptr_empty);
    end
  endtask

  task automatic test_single_queue();
    int g; logic [15:0] pd; bit to; int r[4]; int p1; int e0; int other;
    for (int i = 0; i < 4; i++) r[i] = data_rd_cnt[i];
    p1 = ptr_rd_cnt[1]; e0 = err_cnt;
    push(1, 16'h2040);
    drive_frame(-1, 16'h0, 1'b0, g, pd, to);
    @(negedge clk);
    exp_data[1] += 64;
    other = (data_rd_cnt[0] - r[0]) + (data_rd_cnt[2] - r[2]) + (data_rd_cnt[3] - r[3]);
    n_checks++;
    if (to || g !== 1) begin n_fail++; $display("FAIL single_grant: got %0d timeout %0d want 1", g, to); end
    n_checks++;
    if (pd !== 16'h2040) begin n_fail++; $display("FAIL single_desc: got %h want 2040", pd); end
    n_checks++;
    if (ptr_rd_cnt[1] - p1 !== 1) begin n_fail++; $display("FAIL single_ptr_rd: got %0d want 1", ptr_rd_cnt[1] - p1); end
    n_checks++;
    if (data_rd_cnt[1] - r[1] !== 64 || other !== 0) begin
      n_fail++; $display("FAIL single_data_rd: q1 got %0d want 64, others got %0d want 0", data_rd_cnt[1] - r[1], other);
    end
    n_checks++;
    if ({busy, mac_ptr_empty, grant_q} !== {1'b0, 1'b1, 3'd1}) begin
      n_fail++; $display("FAIL single_idle: busy/empty got %b%b grant %0d want 01 1", busy, mac_ptr_empty, grant_q);
    end
    n_checks++;
    if (mac_data_dout !== 8'(64 + exp_data[1])) begin
      n_fail++; $display("FAIL single_last_byte: got %h want %h", mac_data_dout, 8'(64 + exp_data[1]));
    end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL single_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_round_robin();
    int g; logic [15:0] pd; bit to; int r; int e0;
    int ord [6] = '{0, 1, 2, 3, 0, 3};
    apply_reset();
    e0 = err_cnt;
    for (int q = 0; q < 4; q++) push(q, {5'(q + 8), 11'd60});
    for (int f = 0; f < 6; f++) begin
      if (f == 4) begin
        push(3, {5'(11), 11'd60});
        push(0, {5'(8), 11'd60});
      end
      r = data_rd_cnt[ord[f]];
      drive_frame(-1, 16'h0, 1'b0, g, pd, to);
      @(negedge clk);
      exp_data[ord[f]] += 60;
      n_checks++;
      if (to || g !== ord[f]) begin n_fail++; $display("FAIL rr_order[%0d]: got q%0d want q%0d", f, g, ord[f]); end
      n_checks++;
      if (data_rd_cnt[ord[f]] - r !== 60) begin
        n_fail++; $display("FAIL rr_bytes[%0d]: got %0d want 60", f, data_rd_cnt[ord[f]] - r);
      end
    end
    n_checks++;
    if (mac_data_dout !== 8'(3 * 64 + exp_data[3])) begin
      n_fail++; $display("FAIL rr_last_byte: got %h want %h", mac_data_dout, 8'(3 * 64 + exp_data[3]));
    end
    n_checks++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL rr_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_pause();
    int g; logic [15:0] pd; bit to; int r; int viol;
    apply_reset();
    pause = 1'b1;
    push(2, 16'h5064);
    push(3, 16'h6014);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (mac_ptr_empty !== 1'b1 || busy !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL pause_blocks_grant: got %0d offered cycles want 0", viol); end
    pause = 1'b0;
    r = data_rd_cnt[2];
    drive_frame(-1, 16'h0, 1'b1, g, pd, to);
    exp_data[2] += 100;
    n_checks++;
    if (to || g !== 2) begin n_fail++; $display("FAIL pause_grant: got q%0d want q2", g); end
    n_checks++;
    if (data_rd_cnt[2] - r !== 100) begin
      n_fail++; $display("FAIL pause_frame_bytes: got %0d want 100", data_rd_cnt[2] - r);
    end
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (mac_ptr_empty !== 1'b1 || busy !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL pause_holds_next: got %0d offered cycles want 0", viol); end
    pause = 1'b0;
    r = data_rd_cnt[3];
    drive_frame(-1, 16'h0, 1'b0, g, pd, to);
    exp_data[3] += 20;
    n_checks++;
    if (to || g !== 3 || data_rd_cnt[3] - r !== 20) begin
      n_fail++; $display("FAIL pause_release: got q%0d bytes %0d want q3 bytes 20", g, data_rd_cnt[3] - r);
    end
  endtask

  task automatic test_zero_len();
    int g; logic [15:0] pd; bit to; int r0; int r1; int e0;
    apply_reset();
    push(0, 16'h7800);
    push(1, 16'h7805);
    e0 = err_cnt; r0 = data_rd_cnt[0]; r1 = data_rd_cnt[1];
    drive_frame(-1, 16'h0, 1'b0, g, pd, to);
    @(negedge clk);
    n_checks++;
    if (to || g !== 0 || pd !== 16'h7800) begin n_fail++; $display("FAIL zlen_grant: got q%0d desc %h want q0 7800", g, pd); end
    n_checks++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL zlen_err: got %0d pulses want 1", err_cnt - e0); end
    n_checks++;
    if (data_rd_cnt[0] - r0 !== 0) begin n_fail++; $display("FAIL zlen_no_reads: got %0d want 0", data_rd_cnt[0] - r0); end
    drive_frame(-1, 16'h0, 1'b0, g, pd, to);
    @(negedge clk);
    exp_data[1] += 5;
    n_checks++;
    if (to || g !== 1 || data_rd_cnt[1] - r1 !== 5) begin
      n_fail++; $display("FAIL zlen_next: got q%0d bytes %0d want q1 bytes 5", g, data_rd_cnt[1] - r1);
    end
  endtask

  task automatic test_stray_reads();
    repeat (2) @(negedge clk);
    mac_data_rd = 1'b1;
    #1;
    n_checks++;
    if (q_data_rd !== 4'b0000) begin n_fail++; $display("FAIL idle_data_rd_blocked: got %b want 0000", q_data_rd); end
    @(negedge clk);
    mac_data_rd = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL idle_data_rd_err: got %b want 1", err); end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL idle_err_one_cycle: got %b want 0", err); end
    mac_ptr_rd = 1'b1;
    #1;
    n_checks++;
    if (q_ptr_rd !== 4'b0000) begin n_fail++; $display("FAIL idle_ptr_rd_blocked: got %b want 0000", q_ptr_rd); end
    @(negedge clk);
    mac_ptr_rd = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL idle_ptr_rd_err: got %b want 1", err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int k; int r;
    push(0, 16'h4032);
    r = data_rd_cnt[0];
    k = 0;
    while (mac_ptr_empty !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 100) begin n_fail++; $display("FAIL rstmid_offer: got no offer within %0d cycles want offer", k); end
    mac_ptr_rd = 1'b1;
    @(negedge clk);
    mac_ptr_rd = 1'b0;
    @(negedge clk);
    mac_data_rd = 1'b1;
    repeat (10) @(negedge clk);
    exp_data[0] += 10;
    n_checks++;
    if (data_rd_cnt[0] - r !== 10) begin n_fail++; $display("FAIL rstmid_bytes: got %0d want 10", data_rd_cnt[0] - r); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, err, mac_ptr_empty, grant_q, q_ptr_rd, q_data_rd} !== {3'b001, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: busy/err/empty %b%b%b grant %0d strobes %b want 001 0 00000000",
               busy, err, mac_ptr_empty, grant_q, {q_ptr_rd, q_data_rd});
    end
    mac_data_rd = 1'b0;
    wr_ptr[0] = rd_ptr[0];
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    $display("frame: reset mid transfer q0");
  endtask

`ifdef TXQ_STRICT_PRIO_EN
  task automatic test_strict_prio();
    int g; logic [15:0] pd; bit to;
    int exp_g [5] = '{0, 0, 0, 0, 1};
    apply_reset();
    push(0, 16'h0808);
    push(1, 16'h1808);
    for (int f = 0; f < 5; f++) begin
      drive_frame((f < 3) ? 0 : -1, 16'h0808, 1'b0, g, pd, to);
      exp_data[exp_g[f]] += 8;
      n_checks++;
      if (to || g !== exp_g[f]) begin n_fail++; $display("FAIL strict_order[%0d]: got q%0d want q%0d", f, g, exp_g[f]); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = 0;
      exp_data[i] = 0;
    end
    test_reset();
    test_single_queue();
    test_round_robin();
    test_pause();
    test_zero_len();
    test_stray_reads();
    test_reset_mid_frame();
`ifdef TXQ_STRICT_PRIO_EN
    test_strict_prio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
